// File: rtl/dsm_upconv_core.sv
// dsm_upconv_core
// Single-channel up-converting delta-sigma core. Baseband samples arrive on a
// valid/ready handshake once per frame of R = 2^LOG2_INTERP cycles. They are
// linearly interpolated to the full clock rate, mixed with a mode-selectable
// digital LO, and fed to a first-order, 3-level, dithered delta-sigma
// quantiser. The quantiser drives the 2-bit PWM output stage.
//
// Pipeline: prev/curr/p -> y_r -> m_r -> pwm (one register per stage).

module dsm_upconv_core #(
  parameter int DW          = 20,
  parameter int LOG2_INTERP = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  input  logic [1:0]           lo_mode,
  input  logic signed [DW-1:0] dith_i,
  input  logic                 underrun_clr,
  output logic                 underrun,
  output logic [1:0]           pwm
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  // Interpolator product: (DW+1)-bit difference times an unsigned phase.
  localparam int PW = DW + LOG2_INTERP + 2;
  // Accumulator and the wider working width of the quantiser sum. The sum of
  // a clamped accumulator, a full-scale mixer word and full-scale dither,
  // plus or minus one FS of feedback, needs three bits above DW.
  localparam int AW = DW + 2;
  localparam int VW = DW + 3;

  localparam longint FS_L = longint'(1) << (DW - 1);

  localparam logic signed [VW-1:0] FS_V      = VW'(FS_L);
  localparam logic signed [VW-1:0] HALF_FS   = VW'(FS_L / 2);
  localparam logic signed [VW-1:0] NHALF_FS  = VW'(-(FS_L / 2));
  localparam logic signed [VW-1:0] ACC_MAX   = VW'((FS_L * 2) - 1);
  localparam logic signed [VW-1:0] ACC_MIN   = VW'(-(FS_L * 2));

  localparam logic signed [DW-1:0] Y_MAX     = DW'(FS_L - 1);
  localparam logic signed [DW-1:0] Y_MIN     = DW'(-FS_L);

  // LO mode encodings.
  localparam logic [1:0] LO_MODE_BYPASS = 2'b00;
  localparam logic [1:0] LO_MODE_FS4    = 2'b01;
  localparam logic [1:0] LO_MODE_FS2    = 2'b10;

  // Output codes of the 3-level quantiser.
  localparam logic [1:0] PWM_ZERO = 2'b00;
  localparam logic [1:0] PWM_POS  = 2'b01;
  localparam logic [1:0] PWM_NEG  = 2'b10;

  // Three-valued multiplier shared by the LO and the quantiser decision.
  typedef enum logic [1:0] {
    TRI_ZERO = 2'b00,
    TRI_POS  = 2'b01,
    TRI_NEG  = 2'b10
  } tri_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LOG2_INTERP-1:0] p;
  logic [1:0]             lo_cnt;
  logic [1:0]             lo_mode_r;
  logic signed [DW-1:0]   prev;
  logic signed [DW-1:0]   curr;
  logic signed [DW-1:0]   y_r;
  logic signed [DW-1:0]   m_r;
  logic signed [AW-1:0]   acc;

  // Last cycle of a frame: the only cycle a new sample can be taken.
  logic frame_end;
  assign frame_end = (p == '1);
  assign s_ready   = frame_end && !reset;

  // ---------------------------------------------------------------------------
  // Phase and LO counters: free-running, wrap naturally at their width
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the values held before the edge, which is what the
  // one-cycle-per-stage pipeline relies on.
  always_ff @(posedge clock) begin
    if (reset) begin
      p      <= '0;
      lo_cnt <= '0;
    end else begin
      p      <= p + 1'b1;
      lo_cnt <= lo_cnt + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame-boundary capture: sample pair, LO mode and underrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      prev      <= '0;
      curr      <= '0;
      lo_mode_r <= LO_MODE_FS4;
    end else if (frame_end) begin
      // Without a new sample the segment flattens out at curr.
      prev      <= curr;
      lo_mode_r <= lo_mode;
      if (s_valid) begin
        curr <= s_data;
      end
    end
  end

  // Sticky underrun; a fresh underrun beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      underrun <= 1'b0;
    end else if (frame_end && !s_valid) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Linear interpolator: y = prev + floor((curr - prev) * p / R)
  // ---------------------------------------------------------------------------
  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod;
  logic signed [DW-1:0] y_next;

  assign diff   = {curr[DW-1], curr} - {prev[DW-1], prev};
  assign prod   = PW'(diff) * PW'($signed({1'b0, p}));
  // The arithmetic shift floors toward minus infinity; the result always lies
  // between prev and curr, so truncating back to DW bits is exact.
  assign y_next = prev + DW'(prod >>> LOG2_INTERP);

  // Interpolator output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_r <= '0;
    end else begin
      y_r <= y_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Digital LO and mixer
  // ---------------------------------------------------------------------------
  tri_e                 lo_val;
  logic signed [DW-1:0] y_neg;
  logic signed [DW-1:0] m_next;

  // LO value for the current lo_cnt under the latched mode.
  // NOTE: every combinational output gets a default before the case so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    lo_val = TRI_ZERO;
    case (lo_mode_r)
      LO_MODE_BYPASS: lo_val = TRI_POS;
      LO_MODE_FS4: begin
        case (lo_cnt)
          2'd0:    lo_val = TRI_POS;
          2'd2:    lo_val = TRI_NEG;
          default: lo_val = TRI_ZERO;
        endcase
      end
      LO_MODE_FS2:    lo_val = lo_cnt[0] ? TRI_NEG : TRI_POS;
      default:        lo_val = TRI_ZERO;
    endcase
  end

  // Negating the most negative word would wrap; saturate it instead.
  assign y_neg = (y_r == Y_MIN) ? Y_MAX : -y_r;

  // Mixer product selection.
  always_comb begin
    m_next = '0;
    case (lo_val)
      TRI_POS: m_next = y_r;
      TRI_NEG: m_next = y_neg;
      default: m_next = '0;
    endcase
  end

  // Mixer output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_r <= '0;
    end else begin
      m_r <= m_next;
    end
  end

  // ---------------------------------------------------------------------------
  // First-order 3-level delta-sigma quantiser with dither
  // ---------------------------------------------------------------------------
  logic signed [VW-1:0] dsm_sum;
  logic signed [VW-1:0] dsm_fb;
  logic signed [AW-1:0] acc_next;
  tri_e                 q;

  assign dsm_sum = VW'(acc) + VW'(m_r) + VW'(dith_i);

  // Decision, error feedback and accumulator clamp.
  always_comb begin
    q      = TRI_ZERO;
    dsm_fb = dsm_sum;
    if (dsm_sum >= HALF_FS) begin
      q      = TRI_POS;
      dsm_fb = dsm_sum - FS_V;
    end else if (dsm_sum < NHALF_FS) begin
      q      = TRI_NEG;
      dsm_fb = dsm_sum + FS_V;
    end

    if (dsm_fb > ACC_MAX) begin
      acc_next = AW'(ACC_MAX);
    end else if (dsm_fb < ACC_MIN) begin
      acc_next = AW'(ACC_MIN);
    end else begin
      acc_next = AW'(dsm_fb);
    end
  end

  // Accumulator and output code registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      pwm <= PWM_ZERO;
    end else begin
      acc <= acc_next;
      case (q)
        TRI_POS: pwm <= PWM_POS;
        TRI_NEG: pwm <= PWM_NEG;
        default: pwm <= PWM_ZERO;
      endcase
    end
  end

endmodule

// File: tb/tb_dsm_upconv_core.sv
// tb_dsm_upconv_core
// Directed bench for dsm_upconv_core (DW=20, R=4). Each test resets the core,
// queues the values expected at specific cycles into a scoreboard, then drives
// its input pattern. A monitor on the falling edge pops every entry due in
// the current cycle and compares it with the core.

module tb_dsm_upconv_core;

  localparam int DW = 20;
  localparam int L2 = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic [1:0]           lo_mode;
  logic signed [DW-1:0] dith_i;
  logic                 underrun_clr;
  logic                 underrun;
  logic [1:0]           pwm;

  dsm_upconv_core #(.DW(DW), .LOG2_INTERP(L2)) dut (
    .clock        (clock),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .lo_mode      (lo_mode),
    .dith_i       (dith_i),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .pwm          (pwm)
  );

  always #5 clock = ~clock;

  // Edge counter: number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum {SIG_READY, SIG_YR, SIG_MR, SIG_PWM, SIG_UNDER, SIG_ACC} sig_e;
  typedef struct {
    int     cyc;
    sig_e   sig;
    longint val;
    string  name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   b;          // edge count at which the last reset was released

  // Queue an expectation, keeping the scoreboard ordered by cycle.
  task automatic expect_at(input int c, input sig_e s, input longint v, input string n);
    exp_t e;
    int   pos;
    e.cyc = c; e.sig = s; e.val = v; e.name = n;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  function automatic longint actual(input sig_e s);
    case (s)
      SIG_READY: return longint'(s_ready);
      SIG_YR:    return longint'($signed(dut.y_r));
      SIG_MR:    return longint'($signed(dut.m_r));
      SIG_PWM:   return longint'(pwm);
      SIG_UNDER: return longint'(underrun);
      default:   return longint'($signed(dut.acc));
    endcase
  endfunction

  task automatic check(input string n, input longint act, input longint exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", n, cyc, act, exp_v);
    end
  endtask

  // Monitor: compare every scoreboard entry that falls due this cycle.
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: due at edge %0d, not compared (now %0d)", e.name, e.cyc, cyc);
      end else begin
        check(e.name, actual(e.sig), e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Three reset edges; the first must already clear underrun and pwm.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    expect_at(cyc, SIG_UNDER, 0, "rst_underrun");
    expect_at(cyc, SIG_PWM, 0, "rst_pwm");
    tick();
    tick();
    reset = 1'b0;
    b = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; s_valid = 1'b1; s_data = '0; lo_mode = 2'b00;
    dith_i = '0; underrun_clr = 1'b0;

    // ---- Reset state, s_ready cadence, interpolation 0 -> 4000 ----
    do_reset();
    expect_at(b, SIG_READY, 0, "ready_c0");
    expect_at(b, SIG_PWM, 0, "pwm_after_rst");
    expect_at(b, SIG_UNDER, 0, "under_after_rst");
    expect_at(b + 2, SIG_READY, 0, "ready_c2");
    expect_at(b + 3, SIG_READY, 1, "ready_c3");
    expect_at(b + 4, SIG_READY, 0, "ready_c4");
    expect_at(b + 7, SIG_READY, 1, "ready_c7");
    expect_at(b + 11, SIG_READY, 1, "ready_c11");
    for (int i = 0; i < 4; i++) begin
      expect_at(b + 9 + i, SIG_YR, 1000 * i, $sformatf("interp_y_%0d", i));
      expect_at(b + 10 + i, SIG_MR, 1000 * i, $sformatf("bypass_m_%0d", i));
    end
    expect_at(b + 13, SIG_YR, 4000, "interp_flat");
    for (int k = 0; k < 16; k++) begin
      s_data = (k + 1 <= 4) ? 20'sd0 : 20'sd4000;
      tick();
    end

    // ---- Underrun: hold curr, set-wins-over-clear, later clear ----
    s_valid = 1'b1; s_data = 20'sd8000;
    do_reset();
    expect_at(b + 7, SIG_UNDER, 0, "under_pre");
    expect_at(b + 8, SIG_UNDER, 1, "under_set");
    expect_at(b + 9, SIG_UNDER, 1, "under_sticky");
    expect_at(b + 10, SIG_UNDER, 0, "under_clr");
    for (int i = 0; i < 4; i++) begin
      expect_at(b + 9 + i, SIG_YR, 8000, $sformatf("hold_y_%0d", i));
      expect_at(b + 13 + i, SIG_YR, 8000 + 2000 * i, $sformatf("interp2_y_%0d", i));
    end
    expect_at(b + 15, SIG_UNDER, 0, "under_clear_before");
    expect_at(b + 16, SIG_UNDER, 1, "under_set_wins");
    expect_at(b + 17, SIG_UNDER, 1, "under_still");
    expect_at(b + 18, SIG_UNDER, 0, "under_clr_late");
    expect_at(b + 20, SIG_UNDER, 1, "under_set_again");
    for (int k = 0; k < 22; k++) begin
      int r;
      r = k + 1;
      s_valid      = !((r >= 5 && r <= 8) || (r >= 13 && r <= 16) || r == 20);
      s_data       = (r <= 4) ? 20'sd8000 : ((r <= 8) ? 20'sd12345 : 20'sd16000);
      underrun_clr = (r == 10 || r == 16 || r == 18);
      tick();
    end
    underrun_clr = 1'b0;

    // ---- Mid-frame reset, then DC FS/2 bypass -> pwm 01,00,... ----
    s_valid = 1'b1; s_data = 20'sd262144; lo_mode = 2'b00;
    do_reset();
    expect_at(b, SIG_UNDER, 0, "midrst_underrun");
    expect_at(b, SIG_ACC, 0, "midrst_acc");
    expect_at(b, SIG_YR, 0, "midrst_y");
    expect_at(b + 3, SIG_READY, 1, "midrst_ready");
    expect_at(b + 6, SIG_YR, 65536, "dc_ramp_y");
    expect_at(b + 9, SIG_MR, 196608, "dc_m_ramp");
    expect_at(b + 10, SIG_MR, 262144, "dc_m_flat");
    expect_at(b + 9, SIG_PWM, 0, "dc_pwm_pre");
    for (int i = 0; i < 6; i++)
      expect_at(b + 10 + i, SIG_PWM, (i % 2 == 0) ? 1 : 0, $sformatf("dc_pwm_%0d", i));
    for (int k = 0; k < 16; k++) tick();

    // ---- fs/4 LO, mode change mid-frame applies after next frame edge ----
    s_data = 20'sd524287; lo_mode = 2'b01;
    do_reset();
    expect_at(b + 6, SIG_YR, 131071, "fs4_ramp_y");
    begin
      longint mexp [9] = '{0, -524287, 0, 524287, 0, -524287, 0, 524287, -524287};
      for (int i = 0; i < 9; i++)
        expect_at(b + 10 + i, SIG_MR, mexp[i], $sformatf("lo_m_%0d", i));
    end
    for (int k = 0; k < 19; k++) begin
      lo_mode = (k + 1 >= 14) ? 2'b10 : 2'b01;
      tick();
    end

    // ---- fs/2 LO on -FS: negation saturates ----
    s_data = -20'sd524288; lo_mode = 2'b10;
    do_reset();
    expect_at(b + 7, SIG_YR, -262144, "neg_ramp_y");
    for (int i = 0; i < 4; i++)
      expect_at(b + 10 + i, SIG_MR, (i % 2 == 0) ? 524287 : -524288, $sformatf("fs2_sat_m_%0d", i));
    for (int k = 0; k < 14; k++) tick();

    // ---- Interpolation floors toward minus infinity ----
    s_data = -20'sd5; lo_mode = 2'b00;
    do_reset();
    expect_at(b + 6, SIG_YR, -2, "floor_y1");
    expect_at(b + 7, SIG_YR, -3, "floor_y2");
    expect_at(b + 8, SIG_YR, -4, "floor_y3");
    for (int k = 0; k < 10; k++) tick();

    // ---- Accumulator clamp, positive and negative, with dither ----
    s_data = 20'sd524287; dith_i = 20'sd524287; lo_mode = 2'b00;
    do_reset();
    expect_at(b + 20, SIG_ACC, 1048575, "clamp_pos_acc");
    expect_at(b + 21, SIG_ACC, 1048575, "clamp_pos_acc2");
    expect_at(b + 20, SIG_PWM, 1, "clamp_pos_pwm");
    for (int k = 0; k < 22; k++) tick();

    s_data = -20'sd524288; dith_i = -20'sd524288;
    do_reset();
    expect_at(b + 20, SIG_ACC, -1048576, "clamp_neg_acc");
    expect_at(b + 21, SIG_ACC, -1048576, "clamp_neg_acc2");
    expect_at(b + 20, SIG_PWM, 2, "clamp_neg_pwm");
    for (int k = 0; k < 22; k++) tick();

    // Drain; anything left over is a comparison that never happened.
    for (int i = 0; i < 8 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never compared (due at edge %0d)", e.name, e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dsm_upconv_core.md
# dsm_upconv_core

Parametrised single-channel up-converting delta-sigma core: accepts baseband samples over a valid/ready handshake, linearly interpolates them by 2^LOG2_INTERP, mixes with a mode-selectable digital LO, and drives a first-order, 3-level, dithered delta-sigma quantiser. It supersedes the fixed-width, fixed-fs/4 interpolator/mixer/modulator chain and feeds the 2-bit PWM output stage unchanged.

## Interface
- DW, 20: sample, dither and mixer width (signed two's complement); full scale FS = 2^(DW-1).
- LOG2_INTERP, 2: interpolation ratio R = 2^LOG2_INTERP, range 1..6.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  core accepts s_data this cycle.
- s_data  in  DW  signed baseband sample.
- lo_mode  in  2  00 LO=+1 (bypass), 01 fs/4 (+1,0,-1,0), 10 fs/2 (+1,-1), 11 LO=0 (mute).
- dith_i  in  DW  signed dither, added every cycle.
- underrun_clr  in  1  clears underrun.
- underrun  out  1  sticky: a frame ended without an input sample.
- pwm  out  2  quantiser code: 00 zero, 01 +1, 10 -1 (11 never driven).

## Operation
- Phase counter p, LOG2_INTERP bits, increments every cycle, wraps R-1 -> 0. s_ready = (p == R-1) and not reset.
- Registers prev, curr (DW). At an edge with p == R-1: if s_valid, prev <= curr, curr <= s_data; else prev <= curr, curr unchanged, underrun <= 1.
- underrun: set wins over simultaneous underrun_clr; otherwise underrun_clr clears it.
- lo_mode_r latched from lo_mode at the p == R-1 edge only; mid-frame changes ignored.
- Interpolator: d = curr - prev in DW+1 bits; y = prev + ((d * p) >>> LOG2_INTERP) (arithmetic shift, floor); result fits DW. Registered into y_r.
- LO counter lo_cnt (2 bits) increments every cycle. LO value for lo_cnt k: mode 00 +1; mode 01 k=0 +1, 1 0, 2 -1, 3 0; mode 10 +1 if k even else -1; mode 11 0.
- Mixer: m_r <= y_r, 0, or -y_r; -(-FS) saturates to FS-1.
- DSM, accumulator acc (DW+2 bits signed): v = acc + m_r + dith_i (sign-extended). q = +1 if v >= FS/2; q = -1 if v < -FS/2; else 0. acc <= v - q*FS, clamped to [-2^DW, 2^DW-1]. pwm <= code of q.

## Timing
- Reset values: p=0, prev=curr=y_r=m_r=acc=0, lo_cnt=0, lo_mode_r=01, underrun=0, pwm=00, s_ready=0.
- After reset release, first s_ready at cycle R-1 (counting the first non-reset cycle as 0); thereafter exactly one s_ready cycle per R cycles.
- Pipeline: prev/curr/p -> y_r (1 cycle) -> m_r (1 cycle) -> pwm (1 cycle). A sample accepted at edge t is fully represented in y_r at edge t+R+1 (it becomes prev after one frame); pwm reflects it 2 cycles later.
- m_r written at edge t uses y_r and lo_cnt values held before edge t; the first post-reset write uses lo_cnt=0.
- Reset mid-frame: every register returns to its reset value on the next edge; any accepted-but-unemitted sample is discarded; underrun is cleared.
- No backpressure on the output; pwm updates every cycle.

## Test plan
- Reset: hold 3 cycles, release -> pwm=00, underrun=0; s_ready first high at cycle 3 (R=4), then at 7, 11, ...
- Interpolation, lo_mode=00, dither 0: inputs 0 then 4000 -> y_r sequence 0,1000,2000,3000 over the frame where prev=0 and curr=4000.
- DC 2^18, lo_mode=00, dither 0, streaming -> pwm steady-state alternates 01,00 (mean +0.5 FS).
- DC 2^19-1, lo_mode=01 -> m_r cycles +524287, 0, -524287, 0 in lo_cnt order; lo_mode change mid-frame takes effect only after the next p=3 edge.
- DC -2^19, lo_mode=10 -> m_r alternates -524288 / +524287 (saturated); acc never exceeds clamp bounds.
- Withhold s_valid over one p=3 edge -> underrun=1, y_r holds curr; pulse underrun_clr on the same edge as a new underrun -> remains 1; clear on a later edge -> 0.
